// File: rtl/coin_button_conditioner_if.sv
// rtl/coin_button_conditioner_if.sv - raw button inputs and conditioned pulse outputs
interface coin_button_conditioner_if;
    logic       nickel_btn;
    logic       dime_btn;
    logic       jolt_btn;
    logic       buzz_btn;
    logic       nickel;
    logic       dime;
    logic       jolt;
    logic       buzzWater;
    logic [3:0] pending;

    modport master (
        output nickel_btn, dime_btn, jolt_btn, buzz_btn,
        input  nickel, dime, jolt, buzzWater, pending
    );

    modport slave (
        input  nickel_btn, dime_btn, jolt_btn, buzz_btn,
        output nickel, dime, jolt, buzzWater, pending
    );
endinterface

// File: rtl/coin_button_conditioner.sv
// rtl/coin_button_conditioner.sv - sync, debounce and one-pulse-per-clock arbitration of coin/selection buttons
module coin_button_conditioner #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    coin_button_conditioner_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index matches the pending bit: 3=dime, 2=nickel, 1=buzzWater, 0=jolt.
    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       rise;
    logic [3:0]       grant;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       out_q, out_d;

    assign raw = {bus.dime_btn, bus.nickel_btn, bus.buzz_btn, bus.jolt_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pending_q <= '0;
            out_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The counter tallies consecutive edges where the synced level disagrees with
    // the debounced level; any agreeing sample drops it back to zero.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = HELD;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = REL_CHK;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                REL_CHK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // A fresh press wins over the grant that clears the same bit, so it stays pending.
    always_comb begin
        rise  = '0;
        grant = '0;
        for (int i = 0; i < 4; i++) begin
            rise[i] = (state_q[i] == PRESS_CHK) && sync2_q[i] && (cnt_q[i] == LAST);
        end
        if (pending_q[3])      grant = 4'b1000;
        else if (pending_q[2]) grant = 4'b0100;
        else if (pending_q[1]) grant = 4'b0010;
        else if (pending_q[0]) grant = 4'b0001;
        pending_d = (pending_q & ~grant) | rise;
        out_d     = grant;
    end

    assign bus.dime      = out_q[3];
    assign bus.nickel    = out_q[2];
    assign bus.buzzWater = out_q[1];
    assign bus.jolt      = out_q[0];
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_coin_button_conditioner.sv
// tb/tb_coin_button_conditioner.sv - directed checks of debounce latency, bounce rejection and arbitration
module tb_coin_button_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    coin_button_conditioner_if bus ();

    coin_button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.dime, bus.nickel, bus.buzzWater, bus.jolt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Outputs must be one-hot or zero on every cycle.
    always @(negedge clk) begin
        chk("onehot0", {3'b000, $onehot0(outs())}, 4'b0001);
    end

    initial begin
        bus.nickel_btn = 1'b0;
        bus.dime_btn   = 1'b0;
        bus.jolt_btn   = 1'b0;
        bus.buzz_btn   = 1'b0;

        // 1. reset held while every button bounces
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("reset_outs", outs(), 4'b0000);
            chk("reset_pending", bus.pending, 4'b0000);
            bus.nickel_btn = ~bus.nickel_btn;
            bus.dime_btn   = ~bus.dime_btn;
            bus.jolt_btn   = ~bus.jolt_btn;
            bus.buzz_btn   = ~bus.buzz_btn;
        end
        bus.nickel_btn = 1'b0;
        bus.dime_btn   = 1'b0;
        bus.jolt_btn   = 1'b0;
        bus.buzz_btn   = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(8);
        chk("idle_outs", outs(), 4'b0000);
        chk("idle_pending", bus.pending, 4'b0000);

        // 2. clean dime press held 10 cycles; pulse after edge k+6 only
        bus.dime_btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("dime_early", outs(), 4'b0000);
        end
        tick(1);
        chk("dime_pulse", outs(), 4'b1000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("dime_held", outs(), 4'b0000);
        end
        bus.dime_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("dime_release", outs(), 4'b0000);
        end

        // 3. nickel bounces 1,0,1,0 then settles high
        bus.nickel_btn = 1'b1; tick(1); chk("bounce_a", outs(), 4'b0000);
        bus.nickel_btn = 1'b0; tick(1); chk("bounce_b", outs(), 4'b0000);
        bus.nickel_btn = 1'b1; tick(1); chk("bounce_c", outs(), 4'b0000);
        bus.nickel_btn = 1'b0; tick(1); chk("bounce_d", bus.pending, 4'b0000);
        bus.nickel_btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("nickel_early", outs(), 4'b0000);
        end
        tick(1);
        chk("nickel_pulse", outs(), 4'b0100);
        tick(1);
        chk("nickel_after", outs(), 4'b0000);
        bus.nickel_btn = 1'b0;
        tick(8);

        // 4. nickel, buzz and jolt rise together; served nickel, buzzWater, jolt
        bus.nickel_btn = 1'b1;
        bus.buzz_btn   = 1'b1;
        bus.jolt_btn   = 1'b1;
        tick(6);
        chk("multi_pending3", bus.pending, 4'b0111);
        chk("multi_none", outs(), 4'b0000);
        tick(1);
        chk("multi_nickel", outs(), 4'b0100);
        chk("multi_pending2", bus.pending, 4'b0011);
        tick(1);
        chk("multi_buzz", outs(), 4'b0010);
        chk("multi_pending1", bus.pending, 4'b0001);
        tick(1);
        chk("multi_jolt", outs(), 4'b0001);
        chk("multi_pending0", bus.pending, 4'b0000);
        tick(1);
        chk("multi_done", outs(), 4'b0000);
        bus.nickel_btn = 1'b0;
        bus.buzz_btn   = 1'b0;
        bus.jolt_btn   = 1'b0;
        tick(8);

        // 5. three-cycle buzz glitch is rejected
        bus.buzz_btn = 1'b1;
        tick(3);
        bus.buzz_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_outs", outs(), 4'b0000);
            chk("glitch_pending", bus.pending, 4'b0000);
        end

        // 6. reset two cycles into a dime debounce, dime still held afterwards
        bus.dime_btn = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_async", outs(), 4'b0000);
        tick(2);
        chk("midrst_outs", outs(), 4'b0000);
        chk("midrst_pending", bus.pending, 4'b0000);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("post_rst_early", outs(), 4'b0000);
        end
        tick(1);
        chk("post_rst_pulse", outs(), 4'b1000);
        tick(1);
        chk("post_rst_after", outs(), 4'b0000);
        bus.dime_btn = 1'b0;
        tick(8);
        chk("final_pending", bus.pending, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
